// File: rtl/cgra_acc_responder_if.sv
// Acceleration request/response bundle between the synchronizer (master) and the
// column-side responder (slave). Signal names keep the responder's point of view.
interface cgra_acc_responder_if #(
    parameter int unsigned N_COL    = 4,
    parameter int unsigned KER_ID_W = 4,
    parameter int unsigned LEN_W    = 16
);
    logic [N_COL-1:0]    acc_req_i;
    logic [KER_ID_W-1:0] ker_id_i;
    logic [KER_ID_W-1:0] ker_rd_addr_o;
    logic [LEN_W-1:0]    ker_len_i;
    logic                acc_ack_o;
    logic [N_COL-1:0]    col_start_o;
    logic [N_COL-1:0]    col_stall_i;
    logic [N_COL-1:0]    col_busy_o;
    logic [N_COL-1:0]    acc_end_o;
    logic                err_o;

    // Responder side
    modport slave (
        input  acc_req_i,
        input  ker_id_i,
        input  ker_len_i,
        input  col_stall_i,
        output ker_rd_addr_o,
        output acc_ack_o,
        output col_start_o,
        output col_busy_o,
        output acc_end_o,
        output err_o
    );

    // Synchronizer / kernel memory side
    modport master (
        output acc_req_i,
        output ker_id_i,
        output ker_len_i,
        output col_stall_i,
        input  ker_rd_addr_o,
        input  acc_ack_o,
        input  col_start_o,
        input  col_busy_o,
        input  acc_end_o,
        input  err_o
    );
endinterface

// File: rtl/cgra_acc_responder.sv
// Column-side responder: accepts a column-mapped acceleration request, fetches the
// kernel length from config memory, launches the mapped columns and returns one
// acc_end_o pulse per column when its execution counter runs out.
// Optional feature: define CGRA_ACC_TIMEOUT_EN to add a per-column watchdog (TO_W bits)
// that force-ends a column and flags err_o when it saturates.
module cgra_acc_responder #(
    parameter int unsigned N_COL    = 4,
    parameter int unsigned KER_ID_W = 4,
`ifdef CGRA_ACC_TIMEOUT_EN
    parameter int unsigned TO_W     = 20,
`endif
    parameter int unsigned LEN_W    = 16
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    cgra_acc_responder_if.slave bus
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StFetch  = 2'd1;
    localparam logic [1:0] StLaunch = 2'd2;

    localparam logic [LEN_W-1:0] LenOne = LEN_W'(1);
    localparam logic [LEN_W-1:0] LenTwo = LEN_W'(2);

    logic [1:0]          r_state;
    logic [1:0]          w_state_d;
    logic [N_COL-1:0]    r_req_map;
    logic [KER_ID_W-1:0] r_ker_id;

    logic                w_launch;
    logic                w_err_launch;
    logic [N_COL-1:0]    w_start;
    logic [N_COL-1:0]    w_busy;
    logic [N_COL-1:0]    w_end;
    logic [N_COL-1:0]    w_wd_err;
    logic [LEN_W-1:0]    w_len_eff;

    assign w_launch = (r_state == StLaunch);

    // A column whose end pulse coincides with LAUNCH still counts as occupied, so
    // both the last busy cycle and the end-pulse cycle take part in the overlap check.
    assign w_err_launch = w_launch &&
                          ((r_ker_id == '0) || ((r_req_map & (w_busy | w_end)) != '0));

    assign w_start   = (w_launch && !w_err_launch) ? r_req_map : '0;
    assign w_len_eff = (bus.ker_len_i == '0) ? LenOne : bus.ker_len_i;

    // Next-state logic of the request handshake FSM
    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle:   if (bus.acc_req_i != '0) w_state_d = StFetch;
            StFetch:  w_state_d = StLaunch;
            StLaunch: w_state_d = StIdle;
            default:  w_state_d = StIdle;
        endcase
    end

    // FSM state plus request capture; the id register doubles as the memory address
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= StIdle;
            r_req_map <= '0;
            r_ker_id  <= '0;
        end else begin
            r_state <= w_state_d;
            if ((r_state == StIdle) && (bus.acc_req_i != '0)) begin
                r_req_map <= bus.acc_req_i;
                r_ker_id  <= bus.ker_id_i;
            end
        end
    end

    // Per-column execution state. r_cnt is the number of cycles still to go up to and
    // including the end-pulse cycle; the final step is folded into r_end so that
    // acc_end_o comes straight from a flop one cycle after the last busy cycle.
    for (genvar c = 0; c < N_COL; c++) begin : g_col
        logic             r_busy;
        logic             w_busy_d;
        logic             r_end;
        logic             w_end_d;
        logic [LEN_W-1:0] r_cnt;
        logic [LEN_W-1:0] w_cnt_d;
`ifdef CGRA_ACC_TIMEOUT_EN
        logic [TO_W-1:0]  r_wd;
        logic [TO_W-1:0]  w_wd_d;
        logic [TO_W-1:0]  w_wd_inc;
        logic             r_wd_err;
        logic             w_wd_err_d;
`endif

        // Count down, end, watchdog and (re)load for this column
        always_comb begin
            w_busy_d = r_busy;
            w_end_d  = 1'b0;
            w_cnt_d  = r_cnt;
`ifdef CGRA_ACC_TIMEOUT_EN
            w_wd_inc   = r_wd + TO_W'(1);
            w_wd_d     = r_wd;
            w_wd_err_d = 1'b0;
`endif
            if (r_busy && !bus.col_stall_i[c]) begin
                if (r_cnt <= LenTwo) begin
                    w_busy_d = 1'b0;
                    w_end_d  = 1'b1;
                    w_cnt_d  = '0;
                end else begin
                    w_cnt_d = r_cnt - LenOne;
                end
            end
`ifdef CGRA_ACC_TIMEOUT_EN
            // Watchdog runs on every busy cycle, stalled or not
            if (r_busy) begin
                w_wd_d = w_wd_inc;
                if (w_wd_inc == '1) begin
                    w_busy_d   = 1'b0;
                    w_end_d    = 1'b1;
                    w_cnt_d    = '0;
                    w_wd_err_d = 1'b1;
                    w_wd_d     = '0;
                end
            end
`endif
            if (w_start[c]) begin
                if (w_len_eff == LenOne) begin
                    // Single-cycle kernel: end pulse right after the start pulse
                    w_busy_d = 1'b0;
                    w_end_d  = 1'b1;
                    w_cnt_d  = '0;
                end else begin
                    w_busy_d = 1'b1;
                    w_cnt_d  = w_len_eff;
                end
`ifdef CGRA_ACC_TIMEOUT_EN
                // The start cycle is the watchdog's first counted cycle
                w_wd_d = TO_W'(1);
`endif
            end
        end

        // Column state registers
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_busy <= 1'b0;
                r_end  <= 1'b0;
                r_cnt  <= '0;
            end else begin
                r_busy <= w_busy_d;
                r_end  <= w_end_d;
                r_cnt  <= w_cnt_d;
            end
        end

`ifdef CGRA_ACC_TIMEOUT_EN
        // Watchdog registers
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_wd     <= '0;
                r_wd_err <= 1'b0;
            end else begin
                r_wd     <= w_wd_d;
                r_wd_err <= w_wd_err_d;
            end
        end

        assign w_wd_err[c] = r_wd_err;
`else
        assign w_wd_err[c] = 1'b0;
`endif

        assign w_busy[c] = r_busy;
        assign w_end[c]  = r_end;
    end

    assign bus.ker_rd_addr_o = r_ker_id;
    assign bus.acc_ack_o     = w_launch;
    assign bus.col_start_o   = w_start;
    assign bus.col_busy_o    = w_busy;
    assign bus.acc_end_o     = w_end;
    assign bus.err_o         = w_err_launch | (|w_wd_err);

endmodule

// File: tb/tb_cgra_acc_responder.sv
// Directed bench for cgra_acc_responder: vector table of single requests plus
// hand-written sequences for stalls, overlap errors, back-to-back, simultaneous
// end/launch, watchdog (CGRA_ACC_TIMEOUT_EN) and reset mid-run.
module tb_cgra_acc_responder;
    localparam int unsigned N_COL    = 4;
    localparam int unsigned KER_ID_W = 4;
    localparam int unsigned LEN_W    = 16;
`ifdef CGRA_ACC_TIMEOUT_EN
    localparam int unsigned TO_W     = 4;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cgra_acc_responder_if #(.N_COL(N_COL), .KER_ID_W(KER_ID_W), .LEN_W(LEN_W)) bus ();

    cgra_acc_responder #(
        .N_COL(N_COL),
        .KER_ID_W(KER_ID_W),
`ifdef CGRA_ACC_TIMEOUT_EN
        .TO_W(TO_W),
`endif
        .LEN_W(LEN_W)
    ) u_dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    // Kernel config memory, synchronous read
    logic [LEN_W-1:0] mem [16];
    always @(posedge clk) bus.ker_len_i <= mem[bus.ker_rd_addr_o];

    typedef struct {
        logic [3:0] req;
        logic [3:0] id;
        logic [3:0] exp_start;
        logic       exp_err;
        int         exp_len;
    } vec_t;
    vec_t vecs [7];

    logic       early, ack, err, err_seen;
    logic [3:0] start, endv;
    int         scyc, s0, ecyc, npulse;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Call at posedge+1. Presents a request, captures cycles 0..2, clears it in cycle 3.
    task automatic issue(input logic [3:0] req, input logic [3:0] id,
                         output logic o_early, output logic o_ack, output logic [3:0] o_start,
                         output logic o_err, output logic [3:0] o_end, output int o_scyc);
        bus.acc_req_i = req;
        bus.ker_id_i  = id;
        @(negedge clk);
        o_early = bus.acc_ack_o;
        @(negedge clk);
        o_early = o_early | bus.acc_ack_o;
        @(negedge clk);
        o_ack   = bus.acc_ack_o;
        o_start = bus.col_start_o;
        o_err   = bus.err_o;
        o_end   = bus.acc_end_o;
        o_scyc  = cyc;
        @(posedge clk);
        #1;
        bus.acc_req_i = '0;
        bus.ker_id_i  = '0;
    endtask

    // Bounded wait for an end pulse on any column of mask; ecyc = -1 on expiry
    task automatic wait_end(input logic [3:0] mask, input int budget,
                            output int o_ecyc, output logic o_err);
        o_ecyc = -1;
        o_err  = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((bus.acc_end_o & mask) != '0) begin
                o_ecyc = cyc;
                o_err  = bus.err_o;
                break;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        mem[0] = 16'd7;  mem[1] = 16'd1;  mem[2] = 16'd2;  mem[3] = 16'd5;
        mem[4] = 16'd4;  mem[5] = 16'd0;  mem[6] = 16'd3;  mem[7] = 16'd6;
        mem[8] = 16'd30; mem[9] = 16'd10;

        vecs[0] = '{4'b0001, 4'd3, 4'b0001, 1'b0, 5};
        vecs[1] = '{4'b0110, 4'd2, 4'b0110, 1'b0, 2};
        vecs[2] = '{4'b1000, 4'd1, 4'b1000, 1'b0, 1};
        vecs[3] = '{4'b0100, 4'd5, 4'b0100, 1'b0, 1};
        vecs[4] = '{4'b0001, 4'd0, 4'b0000, 1'b1, 0};
        vecs[5] = '{4'b1111, 4'd6, 4'b1111, 1'b0, 3};
        vecs[6] = '{4'b0011, 4'd7, 4'b0011, 1'b0, 6};

        bus.acc_req_i   = '0;
        bus.ker_id_i    = '0;
        bus.col_stall_i = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_outputs", 32'({bus.acc_ack_o, bus.col_start_o, bus.col_busy_o,
                                  bus.acc_end_o, bus.err_o, bus.ker_rd_addr_o}), 32'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_busy", 32'(bus.col_busy_o), 32'(0));
        @(posedge clk);
        #1;

        // Table-driven single requests from idle
        for (int v = 0; v < 7; v++) begin
            issue(vecs[v].req, vecs[v].id, early, ack, start, err, endv, scyc);
            chk($sformatf("v%0d_early_ack", v), 32'(early), 32'(0));
            chk($sformatf("v%0d_ack", v), 32'(ack), 32'(1));
            chk($sformatf("v%0d_start", v), 32'(start), 32'(vecs[v].exp_start));
            chk($sformatf("v%0d_err", v), 32'(err), 32'(vecs[v].exp_err));
            chk($sformatf("v%0d_addr", v), 32'(bus.ker_rd_addr_o), 32'(vecs[v].id));
            for (int k = 1; k <= vecs[v].exp_len; k++) begin
                @(negedge clk);
                chk($sformatf("v%0d_busy_k%0d", v, k), 32'(bus.col_busy_o),
                    32'((k < vecs[v].exp_len) ? vecs[v].exp_start : 4'b0000));
                chk($sformatf("v%0d_end_k%0d", v, k), 32'(bus.acc_end_o),
                    32'((k == vecs[v].exp_len) ? vecs[v].exp_start : 4'b0000));
            end
            @(negedge clk);
            chk($sformatf("v%0d_quiet", v), 32'({bus.col_busy_o, bus.acc_end_o, bus.err_o}),
                32'(0));
            @(posedge clk);
            #1;
        end

        // Stall: len 4, stalled 3 cycles mid-run -> end at start+7
        issue(4'b0001, 4'd4, early, ack, start, err, endv, scyc);
        chk("stall_start", 32'(start), 32'(4'b0001));
        @(posedge clk);
        #1;
        bus.col_stall_i = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("stall_hold%0d", i), 32'({bus.col_busy_o, bus.acc_end_o}),
                32'({4'b0001, 4'b0000}));
            @(posedge clk);
            #1;
        end
        bus.col_stall_i = '0;
        wait_end(4'b0001, 20, ecyc, err_seen);
        chk("stall_end_delay", 32'(ecyc - scyc), 32'(7));
        @(posedge clk);
        #1;

        // Overlap with busy column 0 -> ack + err, column 0 unaffected
        issue(4'b0001, 4'd9, early, ack, start, err, endv, s0);
        issue(4'b0011, 4'd2, early, ack, start, err, endv, scyc);
        chk("ovl_ack", 32'(ack), 32'(1));
        chk("ovl_err", 32'(err), 32'(1));
        chk("ovl_start", 32'(start), 32'(0));
        @(negedge clk);
        chk("ovl_busy", 32'(bus.col_busy_o), 32'(4'b0001));
        wait_end(4'b0011, 30, ecyc, err_seen);
        chk("ovl_col0_end_delay", 32'(ecyc - s0), 32'(10));
        chk("ovl_col0_end_map", 32'(bus.acc_end_o), 32'(4'b0001));
        @(posedge clk);
        #1;

        // Back-to-back: column 1 requested the cycle after column 0 ends
        issue(4'b0001, 4'd2, early, ack, start, err, endv, scyc);
        @(negedge clk);
        @(negedge clk);
        chk("b2b_col0_end", 32'(bus.acc_end_o), 32'(4'b0001));
        @(posedge clk);
        #1;
        issue(4'b0010, 4'd1, early, ack, start, err, endv, scyc);
        chk("b2b_ack_err_start", 32'({ack, err, start}), 32'({1'b1, 1'b0, 4'b0010}));
        @(negedge clk);
        chk("b2b_col1_end", 32'(bus.acc_end_o), 32'(4'b0010));
        @(posedge clk);
        #1;

        // Column 2 ends in the LAUNCH cycle of a request for column 3
        issue(4'b0100, 4'd6, early, ack, start, err, endv, s0);
        issue(4'b1000, 4'd7, early, ack, start, err, endv, scyc);
        chk("sim_col2_end_at_launch", 32'(endv), 32'(4'b0100));
        chk("sim_col3_ack_err_start", 32'({ack, err, start}), 32'({1'b1, 1'b0, 4'b1000}));
        wait_end(4'b1000, 20, ecyc, err_seen);
        chk("sim_col3_end_delay", 32'(ecyc - scyc), 32'(6));
        @(posedge clk);
        #1;

        // Same, but the request maps the ending column -> overlap error
        issue(4'b0100, 4'd6, early, ack, start, err, endv, s0);
        issue(4'b0100, 4'd1, early, ack, start, err, endv, scyc);
        chk("simovl_end_at_launch", 32'(endv), 32'(4'b0100));
        chk("simovl_ack_err_start", 32'({ack, err, start}), 32'({1'b1, 1'b1, 4'b0000}));
        @(negedge clk);
        chk("simovl_no_reload", 32'({bus.col_busy_o, bus.acc_end_o}), 32'(0));
        @(posedge clk);
        #1;

`ifdef CGRA_ACC_TIMEOUT_EN
        // Permanent stall: watchdog ends the column with err after 15 cycles
        bus.col_stall_i = 4'b0001;
        issue(4'b0001, 4'd8, early, ack, start, err, endv, scyc);
        wait_end(4'b0001, 40, ecyc, err_seen);
        chk("wd_end_delay", 32'(ecyc - scyc), 32'(15));
        chk("wd_err", 32'(err_seen), 32'(1));
        bus.col_stall_i = '0;
        @(negedge clk);
        chk("wd_quiet", 32'({bus.col_busy_o, bus.err_o}), 32'(0));
`else
        // Without the watchdog a stalled column stays busy until released
        bus.col_stall_i = 4'b0001;
        issue(4'b0001, 4'd2, early, ack, start, err, endv, scyc);
        npulse = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.acc_end_o != '0) npulse++;
        end
        chk("stuck_no_end", 32'(npulse), 32'(0));
        chk("stuck_busy", 32'(bus.col_busy_o), 32'(4'b0001));
        @(posedge clk);
        #1;
        bus.col_stall_i = '0;
        wait_end(4'b0001, 5, ecyc, err_seen);
        chk("stuck_release_end", 32'(ecyc >= 0), 32'(1));
        chk("stuck_release_err", 32'(err_seen), 32'(0));
`endif
        @(posedge clk);
        #1;

        // Reset mid-run with all columns busy
        issue(4'b1111, 4'd8, early, ack, start, err, endv, scyc);
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy_before", 32'(bus.col_busy_o), 32'(4'b1111));
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_outputs", 32'({bus.acc_ack_o, bus.col_start_o, bus.col_busy_o,
                                bus.acc_end_o, bus.err_o, bus.ker_rd_addr_o}), 32'(0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        npulse = 0;
        repeat (40) begin
            @(negedge clk);
            if ((bus.acc_end_o != '0) || (bus.col_busy_o != '0)) npulse++;
        end
        chk("rst_no_end", 32'(npulse), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
